palette_engine: RTL
===================

PALETTE_ENGINE -- requirements
Module: palette_engine

Interface
REQ-001 Parameter INDEX_W, default 4, pixel index width (2**INDEX_W entries per bank).
REQ-002 Parameter CH_W, default 4, width of each of red/green/blue.
REQ-003 Parameter NUM_BANKS, default 4, number of selectable palettes; power of two, >=2.
REQ-004 Clk  input  1  sole clock; all state on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 pix_valid  input  1  pixel lookup request this cycle.
REQ-007 pix_index  input  INDEX_W  palette index of requested pixel.
REQ-008 dim  input  2  brightness attenuation, right-shift amount per channel.
REQ-009 frame_start  input  1  single-cycle pulse at vertical blank start.
REQ-010 bank_req  input  clog2(NUM_BANKS)  requested display bank.
REQ-011 wr_en  input  1  palette write strobe.
REQ-012 wr_bank  input  clog2(NUM_BANKS)  bank written.
REQ-013 wr_index  input  INDEX_W  entry written.
REQ-014 wr_rgb  input  3*CH_W  {red, green, blue} written.
REQ-015 out_valid  output  1  out_red/green/blue valid this cycle.
REQ-016 out_red, out_green, out_blue  output  CH_W each  looked-up colour.
REQ-017 active_bank  output  clog2(NUM_BANKS)  bank currently used for lookups.
REQ-018 busy  output  1  high while initialisation runs.

Function
REQ-019 FSM states INIT and RUN; Reset forces INIT; INIT->RUN after last entry cleared.
REQ-020 INIT writes zero to one entry per cycle, bank-major, index-minor; duration NUM_BANKS*2**INDEX_W cycles (64 at defaults); busy=1 throughout, 0 in RUN.
REQ-021 In INIT, wr_en is ignored and out_valid is held 0 regardless of pix_valid.
REQ-022 In RUN, wr_en=1 writes wr_rgb to entry (wr_bank, wr_index) at that edge.
REQ-023 Lookup latency is exactly 2 cycles: pix_valid at edge N yields out_valid at edge N+2; fully pipelined, one lookup per cycle, no stalls.
REQ-024 Read uses active_bank sampled in the same cycle as pix_valid.
REQ-025 Write and lookup to same entry in same cycle returns the old value (read-first); the new value is visible to lookups issued the next cycle.
REQ-026 dim is sampled with pix_valid and travels with the pixel; each channel output = entry channel >> dim (logical, zero-fill); dim=3 with CH_W=4 gives only the MSB shifted to bit 0.
REQ-027 active_bank updates to bank_req only on the cycle frame_start=1 in RUN; bank_req changes at other times have no effect.
REQ-028 frame_start during INIT is ignored; active_bank stays 0 until the first frame_start in RUN.
REQ-029 When out_valid=0, colour outputs are driven 0.

Reset
REQ-030 Reset asserts asynchronously: out_valid=0, colours=0, active_bank=0, busy=1, pipeline valid bits cleared, INIT counter=0.
REQ-031 Reset mid-lookup or mid-INIT discards in-flight pixels and restarts INIT from entry 0; memory contents are not reset directly, only via INIT.

Structure
REQ-032 Package palette_pkg holds default INDEX_W, CH_W, NUM_BANKS, the rgb_t struct typedef and the state enum.
REQ-033 Sub-module palette_bank_ram: one write port, one synchronous read port, read-first, no reset, inferable as block RAM.
REQ-034 palette_engine owns the FSM, init counter, bank latch, dim pipeline and output registers.

Verification
REQ-035 Reset, hold pix_valid=1 -> busy=1 and out_valid=0 for 64 cycles, then busy=0; all lookups return 0,0,0.
REQ-036 Write bank0 index5=F,4,4; at frame_start with bank_req=0, lookup 5 -> out 15,4,4 exactly 2 cycles later.
REQ-037 Bank0 index3=8,0,0, bank2 index3=F,F,F; bank_req=2 without frame_start -> 8,0,0; after frame_start pulse -> 15,15,15.
REQ-038 Same-cycle write index7=D,0,0 over old A,2,2 and lookup 7 -> A,2,2; next-cycle lookup -> D,0,0.
REQ-039 Entry F,D,D looked up with dim=0,1,2,3 on consecutive cycles -> 15/13/13, 7/6/6, 3/3/3, 1/1/1 on consecutive cycles.
REQ-040 Assert Reset 20 cycles into INIT and again with pixels in flight -> out_valid drops immediately; INIT restarts, busy high for full 64 cycles.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared defaults, colour record and controller state encoding for the palette engine.
package palette_pkg;

  localparam int INDEX_W_DEF   = 4;
  localparam int CH_W_DEF      = 4;
  localparam int NUM_BANKS_DEF = 4;

  typedef struct packed {
    logic [CH_W_DEF-1:0] red;
    logic [CH_W_DEF-1:0] green;
    logic [CH_W_DEF-1:0] blue;
  } rgb_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/palette_bank_ram.sv
// Palette storage for all banks: one write port, one registered read port, read-first.
module palette_bank_ram
  import palette_pkg::*;
#(
  parameter int ADDR_W = INDEX_W_DEF + $clog2(NUM_BANKS_DEF),
  parameter int DATA_W = 3 * CH_W_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // No reset so the array maps onto block RAM; contents are cleared by the engine's INIT sweep.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/palette_engine.sv
// Banked colour palette lookup with a 2-cycle pipeline, per-pixel dimming and frame-synchronous bank switching.
// state | meaning
// INIT  | clearing every entry, one per cycle; writes and lookups ignored
// RUN   | lookups, host writes and bank switching active
module palette_engine
  import palette_pkg::*;
#(
  parameter int INDEX_W   = INDEX_W_DEF,
  parameter int CH_W      = CH_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pix_valid_i,
  input  logic [INDEX_W-1:0]           pix_index_i,
  input  logic [1:0]                   dim_i,
  input  logic                         frame_start_i,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_req_i,
  input  logic                         wr_en_i,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank_i,
  input  logic [INDEX_W-1:0]           wr_index_i,
  input  logic [3*CH_W-1:0]            wr_rgb_i,
  output logic                         out_valid_o,
  output logic [CH_W-1:0]              out_red_o,
  output logic [CH_W-1:0]              out_green_o,
  output logic [CH_W-1:0]              out_blue_o,
  output logic [$clog2(NUM_BANKS)-1:0] active_bank_o,
  output logic                         busy_o
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = BANK_W + INDEX_W;
  localparam int DATA_W = 3 * CH_W;
  localparam logic [0:0] S_INIT = ST_INIT;
  localparam logic [0:0] S_RUN  = ST_RUN;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              v1_q;
  logic [1:0]        dim1_q;
  logic              out_valid_q;
  logic [CH_W-1:0]   red_q, green_q, blue_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [CH_W-1:0]   rd_red, rd_green, rd_blue;

  // The init counter doubles as the flat {bank, index} address, giving bank-major order.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    bank_d     = bank_q;
    ram_we     = 1'b0;
    ram_waddr  = {wr_bank_i, wr_index_i};
    ram_wdata  = wr_rgb_i;
    if (state_q == S_INIT) begin
      ram_we     = 1'b1;
      ram_waddr  = init_cnt_q;
      ram_wdata  = '0;
      init_cnt_d = init_cnt_q + ADDR_W'(1);
      if (init_cnt_q == {ADDR_W{1'b1}}) state_d = S_RUN;
    end else begin
      ram_we = wr_en_i;
      if (frame_start_i) bank_d = bank_req_i;
    end
  end

  palette_bank_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i({bank_q, pix_index_i}),
    .rdata_o(ram_rdata)
  );

  assign rd_red   = ram_rdata[3*CH_W-1:2*CH_W];
  assign rd_green = ram_rdata[2*CH_W-1:CH_W];
  assign rd_blue  = ram_rdata[CH_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      bank_q      <= '0;
      v1_q        <= 1'b0;
      dim1_q      <= '0;
      out_valid_q <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      bank_q      <= bank_d;
      v1_q        <= (state_q == S_RUN) && pix_valid_i;
      dim1_q      <= dim_i;
      out_valid_q <= v1_q;
      red_q       <= v1_q ? (rd_red >> dim1_q) : '0;
      green_q     <= v1_q ? (rd_green >> dim1_q) : '0;
      blue_q      <= v1_q ? (rd_blue >> dim1_q) : '0;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_red_o     = red_q;
  assign out_green_o   = green_q;
  assign out_blue_o    = blue_q;
  assign active_bank_o = bank_q;
  assign busy_o        = (state_q == S_INIT);

endmodule
